// File: rtl/cnnip_cmd_master_if.sv
// Command request/response handshake and register bus between the
// CNN IP command master and its register_set slave.
interface cnnip_cmd_master_if;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_kernel_size;
    logic [7:0]  req_kernel_nums;
    logic [1:0]  req_stride;
    logic        req_padding;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_timeout;
    logic        busy;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;
    logic        mem_valid;

    modport master (
        input  req_valid, req_kernel_size, req_kernel_nums,
        input  req_stride, req_padding, rsp_ready,
        input  mem_dout, mem_valid,
        output req_ready, rsp_valid, rsp_timeout, busy,
        output mem_en, mem_we, mem_addr, mem_din
    );

    modport slave (
        output req_valid, req_kernel_size, req_kernel_nums,
        output req_stride, req_padding, rsp_ready,
        output mem_dout, mem_valid,
        input  req_ready, rsp_valid, rsp_timeout, busy,
        input  mem_en, mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/cnnip_cmd_master.sv
// CNN IP command master: writes layer config and START, polls DONE,
// clears START/DONE and returns a response carrying a timeout flag.
module cnnip_cmd_master #(
    parameter int POLL_GAP   = 16,
    parameter int POLL_LIMIT = 1024
) (
    input logic                 clk_a,
    input logic                 arstz_aq,
    cnnip_cmd_master_if.master  bus
);
    typedef enum logic [2:0] {
        IDLE, WR_CFG0, WR_CFG1, WR_START,
        POLL_RD, POLL_WAIT, WR_CLR, RSP
    } state_t;

    localparam int PW = $clog2(POLL_LIMIT) + 1;
    localparam int GW = $clog2(POLL_GAP + 1) + 1;
    localparam logic [PW-1:0] LIM = PW'(POLL_LIMIT);
    localparam logic [GW-1:0] GAP_LAST =
        GW'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

    state_t      state, state_n;
    logic [PW-1:0] poll_cnt, pc_n;
    logic [GW-1:0] gap_cnt, gc_n;
    logic        to_n;
    logic [1:0]  stride_q;
    logic        pad_q;
    logic        en_n;
    logic [3:0]  we_n;
    logic [31:0] addr_n, din_n;
    logic        done;
    logic        unused_dout;

    assign done = bus.mem_valid && bus.mem_dout[0];
    assign unused_dout = ^bus.mem_dout[31:1];

    always_comb begin
        state_n = state;
        pc_n    = poll_cnt;
        gc_n    = gap_cnt;
        to_n    = bus.rsp_timeout;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    state_n = WR_CFG0;
                    pc_n    = '0;
                    gc_n    = '0;
                    to_n    = 1'b0;
                end
            end
            WR_CFG0:  state_n = WR_CFG1;
            WR_CFG1:  state_n = WR_START;
            WR_START: state_n = POLL_RD;
            POLL_RD: begin
                pc_n = poll_cnt + PW'(1);
                if (done) begin
                    state_n = WR_CLR;
                    to_n    = 1'b0;
                end else if (pc_n == LIM) begin
                    state_n = WR_CLR;
                    to_n    = 1'b1;
                end else if (POLL_GAP == 0) begin
                    state_n = POLL_RD;
                end else begin
                    state_n = POLL_WAIT;
                    gc_n    = '0;
                end
            end
            POLL_WAIT: begin
                if (gap_cnt == GAP_LAST) state_n = POLL_RD;
                else gc_n = gap_cnt + GW'(1);
            end
            WR_CLR: state_n = RSP;
            RSP: if (bus.rsp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Bus outputs are decoded from the next state so they leave a flop.
    // CFG0 is issued right after accept, so it uses the live request.
    always_comb begin
        en_n   = 1'b0;
        we_n   = 4'h0;
        addr_n = 32'h0;
        din_n  = 32'h0;
        case (state_n)
            WR_CFG0: begin
                en_n   = 1'b1;
                we_n   = 4'hF;
                addr_n = 32'h8;
                din_n  = {8'h0, bus.req_kernel_size,
                          8'h0, bus.req_kernel_nums};
            end
            WR_CFG1: begin
                en_n   = 1'b1;
                we_n   = 4'hF;
                addr_n = 32'hC;
                din_n  = {15'h0, pad_q, 14'h0, stride_q};
            end
            WR_START: begin
                en_n   = 1'b1;
                we_n   = 4'hF;
                addr_n = 32'h0;
                din_n  = 32'hFFFF_FFFF;
            end
            POLL_RD: begin
                en_n   = 1'b1;
                addr_n = 32'h4;
            end
            WR_CLR: begin
                en_n   = 1'b1;
                we_n   = 4'hF;
            end
            default: en_n = 1'b0;
        endcase
    end

    always_ff @(posedge clk_a or negedge arstz_aq) begin
        if (!arstz_aq) begin
            state           <= IDLE;
            poll_cnt        <= '0;
            gap_cnt         <= '0;
            stride_q        <= 2'b0;
            pad_q           <= 1'b0;
            bus.mem_en      <= 1'b0;
            bus.mem_we      <= 4'h0;
            bus.mem_addr    <= 32'h0;
            bus.mem_din     <= 32'h0;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_timeout <= 1'b0;
            bus.busy        <= 1'b0;
            bus.req_ready   <= 1'b1;
        end else begin
            state           <= state_n;
            poll_cnt        <= pc_n;
            gap_cnt         <= gc_n;
            if (state == IDLE && bus.req_valid) begin
                stride_q <= bus.req_stride;
                pad_q    <= bus.req_padding;
            end
            bus.mem_en      <= en_n;
            bus.mem_we      <= we_n;
            bus.mem_addr    <= addr_n;
            bus.mem_din     <= din_n;
            bus.rsp_valid   <= (state_n == RSP);
            bus.rsp_timeout <= to_n;
            bus.busy        <= (state_n != IDLE);
            bus.req_ready   <= (state_n == IDLE);
        end
    end
endmodule
